// File: rtl/activation_lut_scheduler_if.sv
// Shared-LUT activation port bundle: requester side (master) and scheduler side (slave).
// The LUT read data travels with the bundle because the LUT lives outside the scheduler.
interface activation_lut_scheduler_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]                 req;
    logic [N_REQ*(ADDR_W+FRAC_W)-1:0] x_in;
    logic [ADDR_W-1:0]                lut_address;
    logic signed [DATA_W-1:0]         lut_base;
    logic signed [DATA_W-1:0]         lut_next;
    logic [N_REQ-1:0]                 ack;
    logic signed [DATA_W-1:0]         y;
    logic                             busy;

    modport master (
        output req, x_in, lut_base, lut_next,
        input  lut_address, ack, y, busy
    );

    modport slave (
        input  req, x_in, lut_base, lut_next,
        output lut_address, ack, y, busy
    );
endinterface

// File: rtl/activation_lut_scheduler.sv
// Round-robin arbiter time-sharing one activation LUT between N_REQ requesters,
// with linear interpolation between neighbouring entries and signed saturation.
module activation_lut_scheduler #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4,
    parameter int DATA_W = 8
) (
    input logic                        clk,
    input logic                        rst,
    activation_lut_scheduler_if.slave  bus
);
    localparam int XW    = ADDR_W + FRAC_W;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW1   = DATA_W + 1;
    localparam int PW    = DATA_W + FRAC_W + 2;
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    typedef enum logic [1:0] {IDLE, ADDR, CALC, DONE} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W-1:0]         rr_start;
    logic [XW-1:0]            x_reg;
    logic [ADDR_W-1:0]        lut_address_r;
    logic [N_REQ-1:0]         ack_r;
    logic signed [DATA_W-1:0] y_r;
    logic                     busy_r;

    logic                     found;
    logic [IDX_W-1:0]         pick;
    logic [XW-1:0]            x_pick;

    logic signed [DW1-1:0]    diff;
    logic signed [PW-1:0]     diff_x, frac_x, base_x, prod, shifted, sum;
    logic signed [DATA_W-1:0] y_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.req[(int'(rr_start) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(rr_start) + k) % N_REQ);
            end
        end
    end

    assign x_pick = bus.x_in[int'(pick)*XW +: XW];

    // lut_next is used as supplied, so the external LUT's wrap rule at the top address holds.
    always_comb begin
        diff    = $signed({bus.lut_next[DATA_W-1], bus.lut_next}) -
                  $signed({bus.lut_base[DATA_W-1], bus.lut_base});
        diff_x  = $signed({{(PW-DW1){diff[DW1-1]}}, diff});
        frac_x  = $signed({{(PW-FRAC_W){1'b0}}, x_reg[FRAC_W-1:0]});
        base_x  = $signed({{(PW-DATA_W){bus.lut_base[DATA_W-1]}}, bus.lut_base});
        prod    = diff_x * frac_x;
        shifted = prod >>> FRAC_W;
        sum     = base_x + shifted;
        if (sum > SAT_MAX)      y_next = SAT_MAX[DATA_W-1:0];
        else if (sum < SAT_MIN) y_next = SAT_MIN[DATA_W-1:0];
        else                    y_next = sum[DATA_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            grant_idx     <= '0;
            rr_start      <= '0;
            x_reg         <= '0;
            lut_address_r <= '0;
            ack_r         <= '0;
            y_r           <= '0;
            busy_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx     <= pick;
                        x_reg         <= x_pick;
                        lut_address_r <= x_pick[XW-1 -: ADDR_W];
                        busy_r        <= 1'b1;
                        state         <= ADDR;
                    end
                end
                ADDR: state <= CALC;
                CALC: begin
                    y_r           <= y_next;
                    ack_r         <= N_REQ'(1) << grant_idx;
                    lut_address_r <= '0;
                    state         <= DONE;
                end
                DONE: begin
                    ack_r    <= '0;
                    busy_r   <= 1'b0;
                    // Next search begins just past the requester served now.
                    rr_start <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.lut_address = lut_address_r;
    assign bus.ack         = ack_r;
    assign bus.y           = y_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_activation_lut_scheduler.sv
// Scoreboard bench for activation_lut_scheduler: expected (requester, result) pairs are queued
// at stimulus time and popped whenever the DUT pulses ack.
module tb_activation_lut_scheduler;
    localparam int N_REQ  = 2;
    localparam int ADDR_W = 4;
    localparam int FRAC_W = 4;
    localparam int DATA_W = 8;
    localparam int XW     = ADDR_W + FRAC_W;

    typedef struct {
        int idx;
        int y;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    activation_lut_scheduler_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W)) bus ();

    activation_lut_scheduler #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lut_entry(input int a);
        return (a < 8) ? 16 * a : 0;
    endfunction

    function automatic int lut_next_entry(input int a);
        if (a == 7)  return lut_entry(7);
        if (a == 15) return lut_entry(0);
        return lut_entry(a + 1);
    endfunction

    function automatic int model_y(input logic [7:0] x);
        int a, f, b, n, s;
        a = int'(x[7:4]);
        f = int'(x[3:0]);
        b = lut_entry(a);
        n = lut_next_entry(a);
        s = b + (((n - b) * f) >>> 4);
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    always_comb begin
        bus.lut_base = DATA_W'(lut_entry(int'(bus.lut_address)));
        bus.lut_next = DATA_W'(lut_next_entry(int'(bus.lut_address)));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.ack != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", int'(bus.ack), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_idx", int'(bus.ack), 1 << e.idx);
                check("y", int'(bus.y), e.y);
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst      = 1'b0;
        bus.req  = '0;
        bus.x_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ack", int'(bus.ack), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_addr", int'(bus.lut_address), 0);
        rst = 1'b1;
    endtask

    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.ack == '0 && cycles < 20);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_single(input int idx, input logic [7:0] x);
        int exp_y;
        exp_y    = model_y(x);
        bus.x_in = '0;
        bus.x_in[idx*XW +: XW] = x;
        bus.req  = '0;
        bus.req[idx] = 1'b1;
        sb.push_back('{idx: idx, y: exp_y});
        @(negedge clk);
        bus.req = '0;
        check("busy_addr", int'(bus.busy), 1);
        check("addr_in_addr", int'(bus.lut_address), int'(x[7:4]));
        @(negedge clk);
        check("addr_in_calc", int'(bus.lut_address), int'(x[7:4]));
        check("ack_early", int'(bus.ack), 0);
        @(negedge clk);
        check("ack_latency", int'(bus.ack), 1 << idx);
        check("addr_in_done", int'(bus.lut_address), 0);
        @(negedge clk);
        check("ack_pulse", int'(bus.ack), 0);
        check("busy_idle", int'(bus.busy), 0);
        check("y_hold", int'(bus.y), exp_y);
    endtask

    initial begin
        int cycles;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        bus.req  = '0;
        bus.x_in = '0;

        reset_dut();
        @(negedge clk);
        run_single(0, 8'h25);
        run_single(0, 8'h7A);
        run_single(0, 8'hF8);

        // Both requesters held: grants alternate starting at 0 after reset, 4 cycles apart.
        reset_dut();
        bus.x_in = {8'h25, 8'h63};
        bus.req  = 2'b11;
        for (int k = 0; k < 4; k++)
            sb.push_back('{idx: k % 2, y: (k % 2 == 0) ? 99 : 37});
        for (int k = 0; k < 4; k++) begin
            wait_ack(cycles);
            check("arb_spacing", cycles, (k == 0) ? 3 : 4);
            check("arb_ack", int'(bus.ack), (k % 2 == 0) ? 1 : 2);
        end
        bus.req = '0;
        @(negedge clk);

        // Input changed and request dropped one cycle after grant.
        bus.x_in = {8'h00, 8'h63};
        bus.req  = 2'b01;
        sb.push_back('{idx: 0, y: 99});
        @(negedge clk);
        bus.x_in = '0;
        bus.req  = '0;
        wait_ack(cycles);
        check("hold_latency", cycles, 2);
        @(negedge clk);

        // Reset asserted mid-CALC aborts without ack; then requester 1 is served.
        bus.x_in = {8'h00, 8'h25};
        bus.req  = 2'b01;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ack", int'(bus.ack), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_addr", int'(bus.lut_address), 0);
        check("abort_y", int'(bus.y), 0);
        bus.req  = 2'b10;
        bus.x_in = {8'h7A, 8'h00};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.push_back('{idx: 1, y: 112});
        wait_ack(cycles);
        check("post_reset_latency", cycles, 3);
        bus.req = '0;
        @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            int          idx;
            logic [7:0]  x;
            idx = int'($urandom_range(0, N_REQ - 1));
            x   = 8'($urandom);
            run_single(idx, x);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/activation_lut_scheduler.md
ACTIVATION_LUT_SCHEDULER -- requirements
Module: activation_lut_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters sharing one activation LUT.
REQ-002 SHALL have parameter ADDR_W, default 4, LUT address width and integer part of the input.
REQ-003 SHALL have parameter FRAC_W, default 4, fraction width of the input.
REQ-004 SHALL have parameter DATA_W, default 8, signed LUT entry width and result width.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req, input, N_REQ, per-requester request level.
REQ-008 SHALL have port x_in, input, N_REQ*(ADDR_W+FRAC_W), flattened inputs; slice i belongs to requester i; upper ADDR_W bits are the address, lower FRAC_W bits the fraction.
REQ-009 SHALL have port lut_address, output, ADDR_W, address driven to the shared LUT.
REQ-010 SHALL have port lut_base, input, DATA_W signed, LUT entry at lut_address (combinational).
REQ-011 SHALL have port lut_next, input, DATA_W signed, neighbouring LUT entry for interpolation (combinational).
REQ-012 SHALL have port ack, output, N_REQ, one-cycle completion pulse to the granted requester.
REQ-013 SHALL have port y, output, DATA_W signed, interpolated result; valid only when ack is non-zero.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> ADDR -> CALC -> DONE -> IDLE, advancing one state per cycle except in IDLE.
REQ-016 In IDLE with any req bit high, the block SHALL grant exactly one requester by round-robin, starting the search at the index after the last granted one; after reset the search starts at index 0.
REQ-017 On grant, the block SHALL register the granted index and that requester's x_in slice and go to ADDR.
REQ-018 In ADDR and CALC, lut_address SHALL equal the registered address bits; in IDLE and DONE it SHALL be 0.
REQ-019 In CALC, the block SHALL compute diff = lut_next - lut_base at DATA_W+1 bits signed, prod = diff * frac with frac zero-extended, shift prod right arithmetically by FRAC_W (floor), and sum = lut_base + shifted.
REQ-020 The block SHALL saturate sum to the DATA_W signed range, then register it into y on leaving CALC.
REQ-021 In DONE, ack SHALL be one-hot on the granted index for exactly one cycle, y SHALL hold the result, and the round-robin pointer SHALL update to the granted index.
REQ-022 Latency SHALL be exactly 3 cycles from the IDLE grant edge to the ack-high cycle; the maximum rate is one result per 4 cycles.
REQ-023 Deasserting req after grant SHALL NOT cancel the operation; ack is still issued.
REQ-024 A requester holding req high through its own ack SHALL be treated as a new request, but SHALL be granted only after every other pending requester has been served.
REQ-025 Changes to x_in after grant SHALL NOT affect the result.
REQ-026 When the address is 2^ADDR_W-1, the block SHALL use lut_next exactly as supplied, so the LUT wrap rule applies unmodified.
REQ-027 y SHALL hold its last value outside DONE.

Reset
REQ-028 On rst low, asynchronously and regardless of state, the block SHALL force FSM=IDLE, ack=0, y=0, busy=0, lut_address=0, round-robin pointer=index 0, and clear registered grant and x.
REQ-029 A reset during ADDR, CALC or DONE SHALL abort the operation with no ack; after rst rises, the first edge SHALL evaluate requests afresh.

Verification
(Tests use the LUT contents entry i = 16*i for i=0..7 and 0 for i=8..15; next = entry[i+1], except next = entry[7] at address 7 and next = entry[0] at address 15.)
REQ-030 Single request, req=01, x_in[0]=8'h25 -> ack=01 exactly 3 cycles after grant, y=37 (32 + (16*5>>4)).
REQ-031 Saturation at the table end, x=8'h7A -> y=112 (next equals base); x=8'hF8 -> lut_address=15 during ADDR/CALC, y=0.
REQ-032 Arbitration, req=11 held with x0=8'h63 and x1=8'h25 -> acks alternate 01, 10, 01, ... with y=99 and y=37 respectively, spaced 4 cycles apart.
REQ-033 Hold and cancel, x changed to 8'h00 and req dropped one cycle after grant -> ack still issued with the original result.
REQ-034 Reset in CALC -> no ack, all outputs 0 immediately; after release, req=10 is granted to index 1 and completes normally.
